// File: rtl/lv_bist_seq.sv
// Power-up BIST sequencer: analog BIST with bounded retries, then logic BIST, with per-phase timeouts.
// All outputs registered (one-cycle decision latency); i_bist_req low aborts any active phase.
module lv_bist_seq #(
  parameter int CLK_M       = 48,
  parameter int ABIST_TO_US = 100,
  parameter int LBIST_TO_US = 1000,
  parameter int GAP_CYC     = 4,
  parameter int MAX_RETRY   = 2
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_bist_req,
  input  logic                           i_lbist_en,
  input  logic                           i_lv_abist_rult,
  input  logic                           i_lbist_done,
  input  logic                           i_lbist_fail,
  output logic                           o_bist_en,
  output logic                           o_lbist_start,
  output logic                           o_busy,
  output logic                           o_bist_done,
  output logic [1:0]                     o_fail_code,
  output logic [$clog2(MAX_RETRY+1)-1:0] o_retry_cnt
);

  localparam int ABIST_TO_CYC = ABIST_TO_US * CLK_M;
  localparam int LBIST_TO_CYC = LBIST_TO_US * CLK_M;
  localparam int MAX_TO_CYC   = (ABIST_TO_CYC > LBIST_TO_CYC) ? ABIST_TO_CYC : LBIST_TO_CYC;
  localparam int TW           = $clog2(MAX_TO_CYC + 1);
  localparam int RW           = $clog2(MAX_RETRY + 1);

  localparam logic [TW-1:0] A_LAST    = TW'(ABIST_TO_CYC - 1);
  localparam logic [TW-1:0] L_LAST    = TW'(LBIST_TO_CYC - 1);
  localparam logic [TW-1:0] G_LAST    = TW'(GAP_CYC - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  localparam logic [1:0] CODE_PASS = 2'b00;
  localparam logic [1:0] CODE_AFAIL = 2'b01;
  localparam logic [1:0] CODE_LFAIL = 2'b10;
  localparam logic [1:0] CODE_TO   = 2'b11;

  typedef enum logic [2:0] {IDLE, ABIST, GAP, LBIST, DONE} state_t;

  state_t          state_q, state_d;
  logic            req_q;
  logic            arm_q;
  logic [TW-1:0]   timer_q, timer_d;
  logic            bist_en_q, bist_en_d;
  logic            start_q, start_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [1:0]      code_q, code_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic            start;
  logic            counting;

  // arm_q blocks a restart from a request that was already high when reset released
  assign start    = i_bist_req & ~req_q & arm_q;
  assign counting = (state_q == ABIST) || (state_q == GAP) || (state_q == LBIST);

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    retry_d = retry_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ABIST;
          code_d  = CODE_PASS;
          retry_d = '0;
        end
      end
      ABIST: begin
        if (!i_bist_req) begin
          state_d = IDLE;
          code_d  = CODE_TO;
        end else if (i_lbist_en) begin
          if (!i_lv_abist_rult) begin
            state_d = LBIST;
          end else if (retry_q < RETRY_MAX) begin
            state_d = GAP;
            retry_d = retry_q + RW'(1);
          end else begin
            state_d = DONE;
            code_d  = CODE_AFAIL;
          end
        end else if (timer_q == A_LAST) begin
          state_d = DONE;
          code_d  = CODE_TO;
        end
      end
      GAP: begin
        if (!i_bist_req) begin
          state_d = IDLE;
          code_d  = CODE_TO;
        end else if (timer_q == G_LAST) begin
          state_d = ABIST;
        end
      end
      LBIST: begin
        if (!i_bist_req) begin
          state_d = IDLE;
          code_d  = CODE_TO;
        end else if (i_lbist_done) begin
          state_d = DONE;
          code_d  = i_lbist_fail ? CODE_LFAIL : CODE_PASS;
        end else if (timer_q == L_LAST) begin
          state_d = DONE;
          code_d  = CODE_TO;
        end
      end
      DONE: begin
        if (!i_bist_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q)                timer_d = '0;
    else if (counting && (timer_q != '1))  timer_d = timer_q + TW'(1);
    else                                   timer_d = timer_q;

    bist_en_d = (state_d == ABIST) || (state_d == LBIST);
    start_d   = (state_q == ABIST) && (state_d == LBIST);
    busy_d    = (state_d == ABIST) || (state_d == GAP) || (state_d == LBIST);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      arm_q     <= 1'b0;
      timer_q   <= '0;
      bist_en_q <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      code_q    <= 2'b00;
      retry_q   <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= i_bist_req;
      arm_q     <= arm_q | ~i_bist_req;
      timer_q   <= timer_d;
      bist_en_q <= bist_en_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      code_q    <= code_d;
      retry_q   <= retry_d;
    end
  end

  assign o_bist_en     = bist_en_q;
  assign o_lbist_start = start_q;
  assign o_busy        = busy_q;
  assign o_bist_done   = done_q;
  assign o_fail_code   = code_q;
  assign o_retry_cnt   = retry_q;

endmodule

// File: tb/tb_lv_bist_seq.sv
// Bench for lv_bist_seq: scripted analog/logic BIST stages, outcome predicted from the sequencing rules.
module tb_lv_bist_seq;
  localparam int CLK_M = 48;
  localparam int A_US  = 100;
  localparam int L_US  = 20;
  localparam int GAPC  = 4;
  localparam int MR    = 2;
  localparam int A_CYC = A_US * CLK_M;
  localparam int L_CYC = L_US * CLK_M;

  logic       clk = 1'b0;
  logic       rst, req, len, rult, ldone, lfail;
  logic       o_bist_en, o_lbist_start, o_busy, o_bist_done;
  logic [1:0] o_fail_code;
  logic [1:0] o_retry_cnt;

  int checks = 0;
  int errors = 0;
  int starts = 0;
  int gap_run = 0;
  int gaps[$];

  lv_bist_seq #(.CLK_M(CLK_M), .ABIST_TO_US(A_US), .LBIST_TO_US(L_US),
                .GAP_CYC(GAPC), .MAX_RETRY(MR)) dut (
    .i_clk(clk), .i_rst(rst), .i_bist_req(req), .i_lbist_en(len),
    .i_lv_abist_rult(rult), .i_lbist_done(ldone), .i_lbist_fail(lfail),
    .o_bist_en(o_bist_en), .o_lbist_start(o_lbist_start), .o_busy(o_busy),
    .o_bist_done(o_bist_done), .o_fail_code(o_fail_code), .o_retry_cnt(o_retry_cnt)
  );

  always #5 clk = ~clk;

  // start pulses and lengths of enable-low windows while the sequence is active
  always @(negedge clk) begin
    if (o_lbist_start) starts++;
    if (o_busy && !o_bist_en) gap_run++;
    else if (gap_run != 0) begin
      gaps.push_back(gap_run);
      gap_run = 0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_phase(input int dly, input bit r);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (o_bist_en) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL phase_wait: bist_en got 0 want 1"); end
    repeat (dly) @(negedge clk);
    len = 1'b1; rult = r;
    @(negedge clk);
    len = 1'b0; rult = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 1'b0; len = 1'b0; rult = 1'b0; ldone = 1'b0; lfail = 1'b0;
    #1;
    checks++;
    if ({o_bist_en, o_lbist_start, o_busy, o_bist_done, o_fail_code, o_retry_cnt} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000000",
               {o_bist_en, o_lbist_start, o_busy, o_bist_done, o_fail_code, o_retry_cnt});
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // adly < 0 selects a random analog response delay per phase
  task automatic run_case(input int nfail, input int adly, input int lb_dly, input bit lb_f);
    int exp_retry, exp_starts;
    logic [1:0] exp_code;
    if (nfail > MR) begin
      exp_retry = MR; exp_code = 2'b01; exp_starts = 0;
    end else begin
      exp_retry = nfail; exp_code = lb_f ? 2'b10 : 2'b00; exp_starts = 1;
    end
    starts = 0; gap_run = 0; gaps.delete();
    req = 1'b1;
    @(negedge clk);
    for (int p = 0; p <= nfail && p <= MR; p++)
      do_phase((adly < 0) ? int'($urandom_range(0, 60)) : adly, p < nfail);
    if (exp_starts != 0) begin
      repeat (lb_dly) @(negedge clk);
      ldone = 1'b1; lfail = lb_f;
      @(negedge clk);
      ldone = 1'b0; lfail = 1'b0;
    end
    checks++;
    if (o_bist_done !== 1'b1) begin errors++; $display("FAIL case_done: got %b want 1", o_bist_done); end
    checks++;
    if (o_fail_code !== exp_code) begin errors++; $display("FAIL case_code: got %b want %b", o_fail_code, exp_code); end
    checks++;
    if (o_retry_cnt !== 2'(exp_retry)) begin errors++; $display("FAIL case_retry: got %0d want %0d", o_retry_cnt, exp_retry); end
    checks++;
    if (starts != exp_starts) begin errors++; $display("FAIL case_starts: got %0d want %0d", starts, exp_starts); end
    checks++;
    if (gaps.size() != exp_retry) begin errors++; $display("FAIL case_gap_count: got %0d want %0d", gaps.size(), exp_retry); end
    foreach (gaps[i]) begin
      checks++;
      if (gaps[i] != GAPC) begin errors++; $display("FAIL case_gap_len: got %0d want %0d", gaps[i], GAPC); end
    end
    checks++;
    if ({o_busy, o_bist_en} !== 2'b00) begin errors++; $display("FAIL case_done_idle_outs: got %b want 00", {o_busy, o_bist_en}); end
    req = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_bist_done, o_busy, o_fail_code, o_retry_cnt} !== {2'b00, exp_code, 2'(exp_retry)}) begin
      errors++;
      $display("FAIL case_release: got %b want %b", {o_bist_done, o_busy, o_fail_code, o_retry_cnt},
               {2'b00, exp_code, 2'(exp_retry)});
    end
  endtask

  task automatic test_directed;
    run_case(0, 30, 100, 1'b0);
    run_case(2, 30, 100, 1'b0);
    run_case(3, -1, 0, 1'b0);
    run_case(1, -1, 0, 1'b1);
  endtask

  task automatic test_random;
    for (int n = 0; n < 10; n++)
      run_case(int'($urandom_range(0, 3)), -1, int'($urandom_range(0, 150)), 1'($urandom_range(0, 1)));
  endtask

  task automatic test_abist_timeout;
    req = 1'b1;
    @(negedge clk);
    repeat (A_CYC - 1) @(negedge clk);
    checks++;
    if ({o_busy, o_bist_done} !== 2'b10) begin errors++; $display("FAIL abist_to_early: got %b want 10", {o_busy, o_bist_done}); end
    @(negedge clk);
    checks++;
    if ({o_bist_done, o_fail_code} !== 3'b111) begin errors++; $display("FAIL abist_to: got %b want 111", {o_bist_done, o_fail_code}); end
    req = 1'b0;
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    repeat (A_CYC - 1) @(negedge clk);
    len = 1'b1; rult = 1'b0;
    @(negedge clk);
    len = 1'b0;
    checks++;
    if ({o_lbist_start, o_bist_en, o_busy, o_bist_done} !== 4'b1110) begin
      errors++; $display("FAIL abist_to_boundary: got %b want 1110", {o_lbist_start, o_bist_en, o_busy, o_bist_done});
    end
    ldone = 1'b1;
    @(negedge clk);
    ldone = 1'b0;
    checks++;
    if ({o_bist_done, o_fail_code} !== 3'b100) begin errors++; $display("FAIL abist_boundary_end: got %b want 100", {o_bist_done, o_fail_code}); end
    req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lbist_timeout;
    req = 1'b1;
    do_phase(3, 1'b0);
    repeat (L_CYC - 1) @(negedge clk);
    checks++;
    if ({o_busy, o_bist_done} !== 2'b10) begin errors++; $display("FAIL lbist_to_early: got %b want 10", {o_busy, o_bist_done}); end
    @(negedge clk);
    checks++;
    if ({o_bist_done, o_fail_code} !== 3'b111) begin errors++; $display("FAIL lbist_to: got %b want 111", {o_bist_done, o_fail_code}); end
    req = 1'b0;
    @(negedge clk);
    req = 1'b1;
    do_phase(3, 1'b0);
    repeat (L_CYC - 1) @(negedge clk);
    ldone = 1'b1; lfail = 1'b1;
    @(negedge clk);
    ldone = 1'b0; lfail = 1'b0;
    checks++;
    if ({o_bist_done, o_fail_code} !== 3'b110) begin errors++; $display("FAIL lbist_to_boundary: got %b want 110", {o_bist_done, o_fail_code}); end
    req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort;
    req = 1'b1;
    @(negedge clk);
    ldone = 1'b1; lfail = 1'b1;
    @(negedge clk);
    ldone = 1'b0; lfail = 1'b0;
    checks++;
    if ({o_busy, o_bist_en, o_bist_done} !== 3'b110) begin
      errors++; $display("FAIL ignore_ldone_in_abist: got %b want 110", {o_busy, o_bist_en, o_bist_done});
    end
    do_phase(5, 1'b0);
    repeat (10) @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    checks++;
    if ({o_busy, o_bist_en, o_bist_done, o_fail_code} !== 5'b00011) begin
      errors++; $display("FAIL abort_lbist: got %b want 00011", {o_busy, o_bist_en, o_bist_done, o_fail_code});
    end
  endtask

  task automatic test_reset_abort;
    req = 1'b1;
    @(negedge clk);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({o_bist_en, o_lbist_start, o_busy, o_bist_done, o_fail_code, o_retry_cnt} !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_abist: got %b want 00000000",
               {o_bist_en, o_lbist_start, o_busy, o_bist_done, o_fail_code, o_retry_cnt});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if ({o_busy, o_bist_en, o_bist_done} !== 3'b000) begin
      errors++; $display("FAIL no_restart_after_reset: got %b want 000", {o_busy, o_bist_en, o_bist_done});
    end
    req = 1'b0;
    @(negedge clk);
    req = 1'b1;
    @(negedge clk);
    checks++;
    if ({o_busy, o_bist_en} !== 2'b11) begin errors++; $display("FAIL fresh_edge_restart: got %b want 11", {o_busy, o_bist_en}); end
    req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_abist_timeout;
    test_lbist_timeout;
    test_abort;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lv_bist_seq.md
LV_BIST_SEQ -- requirements
Module: lv_bist_seq

Interface
REQ-001 SHALL have parameter CLK_M, default 48, meaning clock cycles per microsecond.
REQ-002 SHALL have parameter ABIST_TO_US, default 100, meaning analog BIST phase timeout in microseconds; ABIST_TO_CYC = ABIST_TO_US*CLK_M.
REQ-003 SHALL have parameter LBIST_TO_US, default 1000, meaning logic BIST phase timeout in microseconds; LBIST_TO_CYC = LBIST_TO_US*CLK_M.
REQ-004 SHALL have parameter GAP_CYC, default 4, meaning number of cycles o_bist_en is held low between analog retries.
REQ-005 SHALL have parameter MAX_RETRY, default 2, meaning number of analog BIST retries after the first failure.
REQ-006 SHALL have port i_clk, input, 1, single clock; all flops on its rising edge.
REQ-007 SHALL have port i_rst, input, 1, asynchronous, active-high reset.
REQ-008 SHALL have port i_bist_req, input, 1, level BIST request from the top controller.
REQ-009 SHALL have port i_lbist_en, input, 1, analog-phase-complete level from the downstream analog BIST stage.
REQ-010 SHALL have port i_lv_abist_rult, input, 1, analog result; 1 means fail, valid while i_lbist_en=1.
REQ-011 SHALL have port i_lbist_done, input, 1, logic BIST complete.
REQ-012 SHALL have port i_lbist_fail, input, 1, logic BIST result, valid with i_lbist_done.
REQ-013 SHALL have port o_bist_en, output, 1, enable to the analog BIST stage.
REQ-014 SHALL have port o_lbist_start, output, 1, one-cycle logic BIST start pulse.
REQ-015 SHALL have port o_busy, output, 1, high in any state other than IDLE and DONE.
REQ-016 SHALL have port o_bist_done, output, 1, sequence finished.
REQ-017 SHALL have port o_fail_code, output, 2, result code: 00 pass, 01 analog fail, 10 logic fail, 11 timeout.
REQ-018 SHALL have port o_retry_cnt, output, $clog2(MAX_RETRY+1), number of analog retries used.

Function
REQ-019 SHALL implement states IDLE, ABIST, GAP, LBIST and DONE; every output is registered.
REQ-020 SHALL register i_bist_req into req_ff; start = i_bist_req & ~req_ff.
REQ-021 In IDLE, on start SHALL go to ABIST and clear o_fail_code, o_retry_cnt and timer; o_bist_en rises on that same edge.
REQ-022 SHALL hold o_bist_en=1 in ABIST and LBIST, and 0 in IDLE, GAP and DONE.
REQ-023 Timer SHALL clear on every state entry and increment once per cycle in ABIST, GAP and LBIST.
REQ-024 Timer width SHALL be $clog2(max(ABIST_TO_CYC,LBIST_TO_CYC)+1); the timer saturates and never wraps.
REQ-025 In ABIST, when i_lbist_en=1 and i_lv_abist_rult=0, SHALL go to LBIST and drive o_lbist_start=1 for exactly the first LBIST cycle.
REQ-026 In ABIST, when i_lbist_en=1 and i_lv_abist_rult=1, SHALL go to GAP and increment o_retry_cnt if o_retry_cnt<MAX_RETRY; otherwise SHALL go to DONE with code 01.
REQ-027 In ABIST, when timer==ABIST_TO_CYC-1 and i_lbist_en=0, SHALL go to DONE with code 11.
REQ-028 In GAP, when timer==GAP_CYC-1, SHALL go to ABIST, so o_bist_en is low for exactly GAP_CYC cycles.
REQ-029 In LBIST, on i_lbist_done SHALL go to DONE with code 10 if i_lbist_fail=1, else code 00.
REQ-030 In LBIST, when timer==LBIST_TO_CYC-1 without i_lbist_done, SHALL go to DONE with code 11.
REQ-031 Simultaneous completion and timeout in the same cycle: completion (REQ-025/026/029) SHALL win.
REQ-032 In DONE, SHALL hold o_bist_done=1, o_fail_code and o_retry_cnt; when i_bist_req=0, SHALL go to IDLE and clear o_bist_done, keeping code and retry count.
REQ-033 i_bist_req=0 in ABIST, GAP or LBIST SHALL abort to IDLE on the next edge: o_bist_en=0, o_bist_done=0, code 11. Abort has priority over all other transitions.
REQ-034 i_lbist_en and i_lbist_done SHALL be ignored outside ABIST and LBIST respectively.

Reset
REQ-035 While i_rst=1, SHALL immediately force: state IDLE, req_ff=0, timer=0, all outputs 0.
REQ-036 Reset asserted mid-sequence SHALL abort with no done pulse; a new start after reset release requires a fresh 0->1 edge on i_bist_req.

Verification
REQ-037 Pass: req 0->1; i_lbist_en=1, rult=0 after 30 cycles; i_lbist_done=1, fail=0 after 100 cycles -> o_lbist_start single pulse, o_bist_done=1, code 00, retry 0.
REQ-038 Retry: rult=1 on the first two analog phases, 0 on the third -> two GAP windows with o_bist_en low exactly 4 cycles each, retry=2, then LBIST entered.
REQ-039 Analog fail: rult=1 on three analog phases -> DONE, code 01, retry=2, o_lbist_start never asserted.
REQ-040 Timeouts: i_lbist_en never asserted -> DONE at the 4800th ABIST cycle with code 11; i_lbist_en asserted in cycle 4800 itself -> LBIST entered, no timeout.
REQ-041 Abort and reset: req dropped during LBIST -> IDLE next edge, o_bist_en=0, code 11, done=0; i_rst pulsed during ABIST -> all outputs 0 at once, and holding req high after release does not restart.
